// File: rtl/lr_deserializer_sfr.sv
// lr_deserializer_sfr: serial-to-parallel collector (MSB- or LSB-first) with a one-word output holding register
module lr_deserializer_sfr #(
    parameter int SIZE = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      msb_first,
    input  logic                      bit_in,
    input  logic                      bit_valid,
    output logic                      bit_ready,
    output logic [SIZE-1:0]           word_out,
    output logic                      word_valid,
    input  logic                      word_ready,
    output logic [$clog2(SIZE+1)-1:0] bit_count
);
    localparam int CW = $clog2(SIZE+1);

    logic [SIZE-1:0] r_sr;
    logic [SIZE-1:0] r_word;
    logic [CW-1:0]   r_cnt;
    logic            r_dir;
    logic            r_valid;
    logic            w_last;
    logic            w_acc;
    logic            w_dir;
    logic [SIZE-1:0] w_next;

    assign w_last     = r_cnt == CW'(SIZE-1);
    assign bit_ready  = !clear && (!w_last || !r_valid || word_ready);
    assign w_acc      = bit_valid && bit_ready;
    assign w_dir      = (r_cnt == '0) ? msb_first : r_dir;
    assign w_next     = w_dir ? {r_sr[SIZE-2:0], bit_in} : {bit_in, r_sr[SIZE-1:1]};
    assign word_out   = r_word;
    assign word_valid = r_valid;
    assign bit_count  = r_cnt;

    // assembly: shift accepted bits in, latch direction on the first bit, restart after a full word or clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr  <= '0;
            r_cnt <= '0;
            r_dir <= 1'b1;
        end else if (clear) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (w_acc) begin
            if (r_cnt == '0)
                r_dir <= msb_first;
            r_sr  <= w_last ? '0 : w_next;
            r_cnt <= w_last ? '0 : r_cnt + CW'(1);
        end
    end

    // holding register: load on completion (which may coincide with a drain), otherwise drop valid on drain
    always_ff @(posedge clk) begin
        if (rst) begin
            r_word  <= '0;
            r_valid <= 1'b0;
        end else if (w_acc && w_last) begin
            r_word  <= w_next;
            r_valid <= 1'b1;
        end else if (r_valid && word_ready) begin
            r_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_lr_deserializer_sfr.sv
// tb_lr_deserializer_sfr: directed self-checking bench for lr_deserializer_sfr with SIZE=8
module tb_lr_deserializer_sfr;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       msb_first = 1'b1;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       bit_ready;
    logic [7:0] word_out;
    logic       word_valid;
    logic       word_ready = 1'b1;
    logic [3:0] bit_count;
    int         errs = 0;
    int         checks = 0;

    lr_deserializer_sfr #(.SIZE(8)) dut (
        .clk(clk), .rst(rst), .clear(clear), .msb_first(msb_first),
        .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
        .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
        .bit_count(bit_count)
    );

    always #5 clk = ~clk;

    // drive 8 consecutive bits, s[7] first; direction flips from bit flip_at on (8 = never)
    task automatic send_stream(input logic [7:0] s, input logic m0, input int flip_at);
        for (int i = 0; i < 8; i++) begin
            msb_first = (i >= flip_at) ? !m0 : m0;
            bit_valid = 1'b1;
            bit_in    = s[7-i];
            @(negedge clk);
        end
        bit_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (word_valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b want 0", word_valid); end
        checks++; if (word_out !== 8'h00) begin errs++; $display("FAIL reset_word: got %h want 00", word_out); end
        checks++; if (bit_count !== 4'd0) begin errs++; $display("FAIL reset_count: got %0d want 0", bit_count); end
        checks++; if (bit_ready !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b want 1", bit_ready); end
        @(negedge clk);
    endtask

    task automatic test_msb_first();
        logic [7:0] s;
        s = 8'b10100101;
        word_ready = 1'b1;
        msb_first  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (bit_count !== 4'(i)) begin errs++; $display("FAIL msb_count%0d: got %0d want %0d", i, bit_count, i); end
            bit_valid = 1'b1;
            bit_in    = s[7-i];
            @(negedge clk);
        end
        bit_valid = 1'b0;
        checks++; if (word_valid !== 1'b1) begin errs++; $display("FAIL msb_valid: got %b want 1", word_valid); end
        checks++; if (word_out !== 8'hA5) begin errs++; $display("FAIL msb_word: got %h want a5", word_out); end
        checks++; if (bit_count !== 4'd0) begin errs++; $display("FAIL msb_count_wrap: got %0d want 0", bit_count); end
        @(negedge clk);
        checks++; if (word_valid !== 1'b0) begin errs++; $display("FAIL msb_drain: got %b want 0", word_valid); end
    endtask

    task automatic test_lsb_first();
        word_ready = 1'b1;
        send_stream(8'b10100101, 1'b0, 8);
        checks++; if (word_valid !== 1'b1 || word_out !== 8'hA5) begin errs++; $display("FAIL lsb_a5: got %b/%h want 1/a5", word_valid, word_out); end
        send_stream(8'b11000000, 1'b0, 8);
        checks++; if (word_valid !== 1'b1 || word_out !== 8'h03) begin errs++; $display("FAIL lsb_03: got %b/%h want 1/03", word_valid, word_out); end
        send_stream(8'b11110000, 1'b1, 4);
        checks++; if (word_out !== 8'hF0) begin errs++; $display("FAIL latch_msb: got %h want f0", word_out); end
        send_stream(8'b11110000, 1'b0, 4);
        checks++; if (word_out !== 8'h0F) begin errs++; $display("FAIL latch_lsb: got %h want 0f", word_out); end
        @(negedge clk);
        checks++; if (word_valid !== 1'b0) begin errs++; $display("FAIL lsb_drain: got %b want 0", word_valid); end
    endtask

    task automatic test_backpressure();
        logic [7:0] s;
        s = 8'h5A;
        word_ready = 1'b0;
        send_stream(8'h3C, 1'b1, 8);
        checks++; if (word_valid !== 1'b1 || word_out !== 8'h3C) begin errs++; $display("FAIL bp_first: got %b/%h want 1/3c", word_valid, word_out); end
        for (int i = 0; i < 7; i++) begin
            bit_valid = 1'b1;
            bit_in    = s[7-i];
            @(negedge clk);
        end
        checks++; if (word_out !== 8'h3C) begin errs++; $display("FAIL bp_stable: got %h want 3c", word_out); end
        bit_in = s[0];
        #1;
        checks++; if (bit_count !== 4'd7) begin errs++; $display("FAIL bp_count7: got %0d want 7", bit_count); end
        checks++; if (bit_ready !== 1'b0) begin errs++; $display("FAIL bp_stall: got %b want 0", bit_ready); end
        @(negedge clk);
        checks++; if (bit_count !== 4'd7 || word_out !== 8'h3C || word_valid !== 1'b1) begin errs++; $display("FAIL bp_held: got %0d/%h/%b want 7/3c/1", bit_count, word_out, word_valid); end
        word_ready = 1'b1;
        #1;
        checks++; if (bit_ready !== 1'b1) begin errs++; $display("FAIL bp_release: got %b want 1", bit_ready); end
        @(negedge clk);
        bit_valid  = 1'b0;
        word_ready = 1'b0;
        checks++; if (word_valid !== 1'b1 || word_out !== 8'h5A || bit_count !== 4'd0) begin errs++; $display("FAIL bp_second: got %b/%h/%0d want 1/5a/0", word_valid, word_out, bit_count); end
        word_ready = 1'b1;
        @(negedge clk);
        checks++; if (word_valid !== 1'b0) begin errs++; $display("FAIL bp_drain: got %b want 0", word_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w [3];
        logic       ev;
        w[0] = 8'h12;
        w[1] = 8'h34;
        w[2] = 8'h56;
        word_ready = 1'b1;
        msb_first  = 1'b1;
        for (int c = 0; c < 26; c++) begin
            ev = (c == 8) || (c == 16) || (c == 24);
            checks++; if (word_valid !== ev) begin errs++; $display("FAIL b2b_valid%0d: got %b want %b", c, word_valid, ev); end
            if (ev) begin
                checks++; if (word_out !== w[c/8-1]) begin errs++; $display("FAIL b2b_word%0d: got %h want %h", c, word_out, w[c/8-1]); end
            end
            bit_valid = c < 24;
            bit_in    = (c < 24) ? w[c/8][7-c%8] : 1'b0;
            #1;
            if (c < 24) begin
                checks++; if (bit_ready !== 1'b1) begin errs++; $display("FAIL b2b_ready%0d: got %b want 1", c, bit_ready); end
            end
            @(negedge clk);
        end
        bit_valid = 1'b0;
    endtask

    task automatic test_clear();
        word_ready = 1'b0;
        send_stream(8'h99, 1'b1, 8);
        send_stream(8'b10100000, 1'b1, 8);
        checks++; if (word_out !== 8'h99) begin errs++; $display("FAIL clr_pend_pre: got %h want 99", word_out); end
        // send_stream above pushes only... full 8 bits would stall; use 3 bits instead below
    endtask

    task automatic test_clear_mid_word();
        logic [7:0] s;
        s = 8'b10100000;
        word_ready = 1'b0;
        send_stream(8'h99, 1'b1, 8);
        for (int i = 0; i < 3; i++) begin
            bit_valid = 1'b1;
            bit_in    = s[7-i];
            @(negedge clk);
        end
        checks++; if (bit_count !== 4'd3) begin errs++; $display("FAIL clr_count3: got %0d want 3", bit_count); end
        clear  = 1'b1;
        bit_in = 1'b1;
        #1;
        checks++; if (bit_ready !== 1'b0) begin errs++; $display("FAIL clr_ready: got %b want 0", bit_ready); end
        @(negedge clk);
        clear     = 1'b0;
        bit_valid = 1'b0;
        checks++; if (bit_count !== 4'd0) begin errs++; $display("FAIL clr_count0: got %0d want 0", bit_count); end
        checks++; if (word_valid !== 1'b1 || word_out !== 8'h99) begin errs++; $display("FAIL clr_pending: got %b/%h want 1/99", word_valid, word_out); end
        word_ready = 1'b1;
        send_stream(8'hC3, 1'b1, 8);
        checks++; if (word_valid !== 1'b1 || word_out !== 8'hC3) begin errs++; $display("FAIL clr_next: got %b/%h want 1/c3", word_valid, word_out); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [7:0] s;
        s = 8'b10110000;
        word_ready = 1'b0;
        send_stream(8'h77, 1'b1, 8);
        for (int i = 0; i < 5; i++) begin
            bit_valid = 1'b1;
            bit_in    = s[7-i];
            @(negedge clk);
        end
        bit_valid = 1'b0;
        checks++; if (bit_count !== 4'd5 || word_valid !== 1'b1) begin errs++; $display("FAIL rst_pre: got %0d/%b want 5/1", bit_count, word_valid); end
        rst       = 1'b1;
        bit_valid = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        bit_valid = 1'b0;
        #1;
        checks++; if (word_valid !== 1'b0 || word_out !== 8'h00) begin errs++; $display("FAIL rst_hold: got %b/%h want 0/00", word_valid, word_out); end
        checks++; if (bit_count !== 4'd0 || bit_ready !== 1'b1) begin errs++; $display("FAIL rst_asm: got %0d/%b want 0/1", bit_count, bit_ready); end
        @(negedge clk);
        word_ready = 1'b1;
        send_stream(8'hE1, 1'b1, 8);
        checks++; if (word_valid !== 1'b1 || word_out !== 8'hE1) begin errs++; $display("FAIL rst_next: got %b/%h want 1/e1", word_valid, word_out); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_backpressure();
        test_back_to_back();
        test_clear_mid_word();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/lr_deserializer_sfr.md
Name: lr_deserializer_sfr

Overview:
- Serial-to-parallel collector: the receive-side counterpart of the left/right shift SFR, which emits a word one bit per shift.
- Accepts one bit per cycle over a valid/ready handshake. Shifts each bit in either MSB-first (left shift) or LSB-first (right shift).
- Presents each completed SIZE-bit word in a one-entry output holding register with its own valid/ready handshake.
- Sits between a serial link/bit source and a word-wide consumer (register file, FIFO, ALU operand path).

Parameters:
- SIZE, default 32: word width in bits. Legal range is SIZE >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- clear  input  1  synchronous abort of the partial word being assembled; does not affect the holding register.
- msb_first  input  1  1 = bits arrive MSB first (shift left, insert at bit 0); 0 = LSB first (shift right, insert at bit SIZE-1).
- bit_in  input  1  serial data bit.
- bit_valid  input  1  bit_in is valid this cycle.
- bit_ready  output  1  block accepts bit_in this cycle.
- word_out  output  SIZE  completed word (holding register).
- word_valid  output  1  word_out holds an unconsumed word.
- word_ready  input  1  consumer takes word_out this cycle.
- bit_count  output  clog2(SIZE+1)  number of bits of the current partial word accepted so far, 0..SIZE-1.

Behaviour:
- Internal state:
  - sr[SIZE-1:0]: assembly shift register.
  - cnt: bit counter, drives bit_count.
  - dir: latched direction.
  - Holding register: word_out plus word_valid.
- Reset (rst=1 at a clk edge): sr=0, cnt=0, dir=1, word_out=0, word_valid=0. Effect of reset on bit_ready:
  - bit_ready is combinational.
  - After reset it equals !clear, because word_valid=0.
  - rst overrides everything else; an in-flight handshake in the reset cycle is discarded.
- Bit accept condition: bit_valid && bit_ready.
- bit_ready = !clear && (cnt != SIZE-1 || !word_valid || word_ready).
  - The block stalls only when the next bit would complete a word while the holding register is full and not draining.
- Direction:
  - dir <= msb_first when a bit is accepted with cnt==0.
  - For bits with cnt>0, the latched dir is used; msb_first changes mid-word are ignored.
  - The first bit of a word uses msb_first directly.
- Shift on accept:
  - dir=1: next = {sr[SIZE-2:0], bit_in}.
  - dir=0: next = {bit_in, sr[SIZE-1:1]}.
- Accept with cnt < SIZE-1: sr <= next, cnt <= cnt+1.
- Accept with cnt == SIZE-1 (word completion): word_out <= next, word_valid <= 1, sr <= 0, cnt <= 0.
  - Latency: word_valid rises the cycle after the last bit is accepted.
- Output drain: word_valid && word_ready clears word_valid next cycle, unless a completion occurs in the same cycle.
  - Simultaneous drain and completion: word_valid stays 1 and word_out takes the new word. No bubble, no loss.
- word_out is held stable while word_valid=1 and word_ready=0.
  - A word is never overwritten before it is consumed; this is guaranteed by bit_ready.
- clear=1 (and rst=0): sr <= 0, cnt <= 0. bit_ready is 0, so a bit presented in that cycle is not accepted (clear wins). The holding register and its handshake are unaffected.
- With no accept and no clear, sr and cnt hold.
- Sustained throughput: 1 bit/cycle, provided the consumer asserts word_ready at least once per SIZE cycles.

Test Plan (SIZE=8):
- MSB-first word: msb_first=1, word_ready=1, stream bits 1,0,1,0,0,1,0,1 on consecutive cycles.
  - Required: word_out=8'hA5 and word_valid=1 exactly one cycle after the 8th accept, then word_valid=0 the following cycle.
  - Required: bit_count steps 0..7 then back to 0.
- LSB-first word: msb_first=0, stream 1,0,1,0,0,1,0,1 → word_out=8'hA5. With the same stream 1,1,0,0,0,0,0,0 → word_out=8'h03.
  - Then toggle msb_first at bit 4 of a word: the result still follows the direction latched at bit 0.
- Backpressure: word_ready=0, stream 16 bits continuously.
  - Required: first word valid and stable.
  - Required: bit_ready=0 when bit_count=7, with the 16th bit held off.
  - Raise word_ready for one cycle: the 16th bit is accepted that same cycle, word_valid stays 1 and word_out updates to the second word.
- Back-to-back full rate: word_ready=1, 24 continuous bits giving words 8'h12, 8'h34, 8'h56.
  - Required: bit_ready never drops; three word_valid pulses, 8 cycles apart, with the correct values.
- Clear mid-word: accept 3 bits, assert clear with bit_valid=1.
  - Required: bit_ready=0 that cycle and bit_count=0 next cycle.
  - Required: the next 8 bits 8'hC3 (MSB first) yield exactly 8'hC3.
  - Required: a pending word_valid word survives the clear unchanged.
- Reset mid-operation: rst=1 with bit_count=5 and word_valid=1 → next cycle word_valid=0, word_out=0, bit_count=0, bit_ready=1. The subsequent 8-bit word assembles correctly.
